mem_interface_unit: RTL and testbench
=====================================

# mem_interface_unit

Word-wide memory access sequencer sitting directly downstream of the multicycle control FSM in the MIPS datapath. It accepts one fetch or data access at a time from the control stage and drives a variable-latency external memory bus with a request/ready handshake. It captures read data into the instruction register (fetch) or memory data register (load) and reports completion, alignment faults and bus timeouts back to control.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, maximum ACCESS cycles without mem_ready before a timeout fault (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  access request from control; sampled only in IDLE
- req_fetch  in  1  1 = instruction fetch (load ir), 0 = data access
- req_we  in  1  1 = write; ignored when req_fetch=1
- req_addr  in  ADDR_W  byte address, must be word-aligned
- req_wdata  in  DATA_W  store data
- err_clr  in  1  clears fault, returns ERROR→IDLE
- busy  out  1  high while state==ACCESS; control holds its state while high
- done  out  1  registered one-cycle completion pulse
- err  out  1  sticky fault flag
- err_code  out  2  01 misaligned, 10 timeout, 00 none
- ir  out  DATA_W  instruction register
- mdr  out  DATA_W  memory data register
- mem_req  out  1  bus request, held until ready or timeout
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address (latched)
- mem_wdata  out  DATA_W  bus write data (latched)
- mem_rdata  in  DATA_W  bus read data, valid when mem_ready=1
- mem_ready  in  1  bus completion, one or more cycles

## Operation
- States: IDLE, ACCESS, ERROR.
- IDLE: on req_valid=1:
  - req_addr[1:0]≠0 → ERROR, err=1, err_code=01, no bus activity, no done.
  - else latch addr, wdata, fetch, we&~fetch; clear wait counter; → ACCESS.
- ACCESS: mem_req=1, mem_addr/mem_we/mem_wdata stable from latches. Wait counter +1 per cycle with mem_ready=0.
  - mem_ready=1 → IDLE. On that edge, read+fetch: ir←mem_rdata; read+data: mdr←mem_rdata; write: ir, mdr unchanged. done=1 next cycle.
  - counter reaches TIMEOUT with mem_ready=0 → ERROR, err=1, err_code=10, mem_req drops, no capture.
- ERROR: req_valid ignored; late mem_ready ignored; err_clr=1 → IDLE, err=0, err_code=00. err_clr outside ERROR has no effect.
- req_valid while busy is ignored, not queued.
- A fetch with req_we=1 is a read.
- Word accesses only; no byte or half-word lanes.

## Timing
- Reset: state IDLE; busy, done, err, mem_req, mem_we = 0; err_code=00; ir, mdr, mem_addr, mem_wdata = 0. Asynchronous, so mem_req drops immediately mid-access with no capture.
- Request accepted at edge 0 → mem_req and busy high from cycle 1.
- mem_ready sampled high at edge k (k≥1) → busy and mem_req low, ir/mdr updated, and done high during cycle k+1 only.
- Minimum latency: accept-to-done is 2 edges (ready in first ACCESS cycle).
- New req_valid may be accepted in the same cycle done is high (state is IDLE), so back-to-back accesses are allowed.
- Timeout: with ready never asserted, mem_req stays high for exactly TIMEOUT cycles, then err=1 on the following edge.
- mem_ready in the same cycle the counter hits TIMEOUT: ready wins, normal completion.
- Misaligned fault: err high on the edge after req_valid; busy never asserts.

## Test plan
- Reset, then fetch 0x0000_0040 with mem_ready in the first ACCESS cycle and rdata 0x012A4020 → mem_req high 1 cycle, ir=0x012A4020 and done pulse 2 edges after accept; mdr unchanged.
- Data load 0x100 with ready after 3 wait cycles and rdata 0xDEADBEEF → busy high 4 cycles, mdr=0xDEADBEEF, ir unchanged. Back-to-back store 0x104/0xCAFEF00D accepted on the done cycle → mem_we=1 and mem_wdata=0xCAFEF00D while pending.
- Load at 0x102 → err=1, err_code=01, mem_req never asserts. Further req_valid ignored. err_clr → IDLE, a subsequent aligned load succeeds.
- mem_ready held low → mem_req high exactly 15 cycles, then err=1 and err_code=10. Later mem_ready pulse causes no mdr change.
- mem_ready asserted on the 15th wait cycle → normal done, err stays 0.
- rst asserted in the middle of a pending access → mem_req, busy and all outputs 0 immediately; no capture; a fresh fetch after release works normally.

Source files
------------

// File: rtl/mem_interface_unit.sv
// mem_interface_unit: word-wide memory access sequencer between the multicycle
// control FSM and a variable-latency request/ready memory bus.
// Latency: accept edge -> mem_req from next cycle; mem_ready edge -> done pulse
// in the following cycle (minimum accept-to-done is 2 edges).
// Backpressure: one access at a time; req_valid is only sampled in IDLE and is
// dropped (not queued) while busy or faulted. A bus that never answers is cut
// off after TIMEOUT cycles with a timeout fault.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_*                  access request from control (valid/fetch/we/addr/wdata)
//   err_clr                clears a sticky fault and returns to IDLE
//   busy, done             access in flight / one-cycle completion pulse
//   err, err_code          sticky fault flag; 01 misaligned, 10 timeout
//   ir, mdr                instruction register / memory data register
//   mem_req/we/addr/wdata  bus request and latched bus command
//   mem_rdata, mem_ready   bus read data and completion
module mem_interface_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_fetch,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              err_clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter value on the last permitted wait cycle; a miss here times out.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t        state;
  logic          fetch_q;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_q   <= 1'b0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      ir        <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_addr[1:0] != 2'b00) begin
              // Misaligned: fault without touching the bus.
              state    <= ERROR;
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              state     <= ACCESS;
              busy      <= 1'b1;
              mem_req   <= 1'b1;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              fetch_q   <= req_fetch;
              // A fetch is always a read, whatever req_we says.
              mem_we    <= req_we & ~req_fetch;
              wait_cnt  <= '0;
            end
          end
        end

        ACCESS: begin
          // Ready takes priority over the timeout on the last wait cycle.
          if (mem_ready) begin
            state   <= IDLE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) begin
              if (fetch_q) ir  <= mem_rdata;
              else         mdr <= mem_rdata;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            state    <= ERROR;
            busy     <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ERROR: begin
          // Requests and stray mem_ready are ignored until the fault is cleared.
          if (err_clr) begin
            state    <= IDLE;
            err      <= 1'b0;
            err_code <= 2'b00;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface_unit.sv
// Bench for mem_interface_unit: directed accesses; expected completion/fault
// events are queued at issue time and checked by an independent monitor.
module tb_mem_interface_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_fetch;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        err_clr;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  mem_interface_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_fetch (req_fetch),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .err_clr   (err_clr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .ir        (ir),
    .mdr       (mdr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] ir;
    logic [31:0] mdr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_ir  = 32'h0;
  logic [31:0] exp_mdr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_done();
    exp_t e;
    e.is_err = 1'b0; e.code = 2'b00; e.ir = exp_ir; e.mdr = exp_mdr;
    sb.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.ir = 32'h0; e.mdr = 32'h0;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per done pulse or err rising edge.
  logic err_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      err_seen = 1'b0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected_done: got done=1 expected no event at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_kind_done", 32'(1'b0), 32'(e.is_err));
          chk("sb_ir", ir, e.ir);
          chk("sb_mdr", mdr, e.mdr);
        end
      end
      if (err && !err_seen) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected_err: got err=1 expected no event at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_kind_err", 32'(1'b1), 32'(e.is_err));
          chk("sb_err_code", 32'(err_code), 32'(e.code));
        end
      end
      err_seen = err;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic fetch, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1; req_fetch = fetch; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_fetch = 1'b0; req_we = 1'b0;
  endtask

  // Holds mem_ready low for 'waits' cycles then high for one; counts mem_req cycles
  // and checks the latched bus command on the first ACCESS cycle.
  task automatic serve(input int waits, input logic [31:0] rdata, input logic [31:0] addr,
                       input logic we, input logic [31:0] wdata, output int cyc);
    cyc = 0;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        mem_ready = 1'b1; mem_rdata = rdata;
      end
      @(negedge clk);
      if (mem_req) cyc++;
      if (i == 0) begin
        chk("bus_addr", mem_addr, addr);
        chk("bus_we", 32'(mem_we), 32'(we));
        if (we) chk("bus_wdata", mem_wdata, wdata);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; req_valid = 1'b0; req_fetch = 1'b0; req_we = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; err_clr = 1'b0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_code", 32'(err_code), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    @(posedge clk); #1;

    // Fetch, ready in first ACCESS cycle.
    exp_ir = 32'h012A4020; push_done();
    issue(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    serve(0, 32'h012A4020, 32'h40, 1'b0, 32'h0, cyc);
    chk("fetch_req_cycles", cyc, 32'd1);
    @(negedge clk);
    chk("fetch_done_busy", 32'(busy), 32'h0);
    chk("fetch_done_mem_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;

    // Load with 3 wait cycles, then back-to-back store on the done cycle.
    exp_mdr = 32'hDEADBEEF; push_done();
    issue(1'b0, 1'b0, 32'h100, 32'h0);
    serve(3, 32'hDEADBEEF, 32'h100, 1'b0, 32'h0, cyc);
    chk("load_busy_cycles", cyc, 32'd4);
    push_done();
    issue(1'b0, 1'b1, 32'h104, 32'hCAFEF00D);
    serve(1, 32'h5555_5555, 32'h104, 1'b1, 32'hCAFEF00D, cyc);
    chk("store_req_cycles", cyc, 32'd2);

    // Misaligned load, ignored request, clear, then a good load.
    push_err(2'b01);
    issue(1'b0, 1'b0, 32'h102, 32'h0);
    @(negedge clk);
    chk("mis_busy", 32'(busy), 32'h0);
    chk("mis_mem_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'h108, 32'h0);
    @(negedge clk);
    chk("err_ignore_busy", 32'(busy), 32'h0);
    chk("err_ignore_mem_req", 32'(mem_req), 32'h0);
    chk("err_sticky", 32'(err), 32'h1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_err_code", 32'(err_code), 32'h0);
    @(posedge clk); #1;
    exp_mdr = 32'h1111_2222; push_done();
    issue(1'b0, 1'b0, 32'h200, 32'h0);
    serve(0, 32'h1111_2222, 32'h200, 1'b0, 32'h0, cyc);

    // Timeout: ready never comes.
    push_err(2'b10);
    issue(1'b0, 1'b0, 32'h300, 32'h0);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) cyc++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", cyc, 32'd15);
    chk("timeout_err_code", 32'(err_code), 32'h2);
    mem_ready = 1'b1; mem_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("late_ready_mdr", mdr, exp_mdr);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;

    // Ready on the 15th wait cycle wins over timeout.
    exp_mdr = 32'h0F0F_0F0F; push_done();
    issue(1'b0, 1'b0, 32'h400, 32'h0);
    serve(14, 32'h0F0F_0F0F, 32'h400, 1'b0, 32'h0, cyc);
    chk("edge_req_cycles", cyc, 32'd15);
    @(negedge clk);
    chk("edge_no_err", 32'(err), 32'h0);
    @(posedge clk); #1;

    // Asynchronous reset mid-access.
    issue(1'b1, 1'b0, 32'h500, 32'h0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ir", ir, 32'h0);
    chk("arst_mdr", mdr, 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    exp_ir = 32'h0; exp_mdr = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_ir = 32'hAABB_CCDD; push_done();
    issue(1'b1, 1'b1, 32'h600, 32'h0);
    serve(2, 32'hAABB_CCDD, 32'h600, 1'b0, 32'h0, cyc);
    chk("post_rst_req_cycles", cyc, 32'd3);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
